// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] RESET_PTR = 4'd15;

    typedef enum logic {IDLE, GRANTED} arb_state_t;
endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set req bit strictly after last_ptr, wrapping 15->0.
module rr_priority_select
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_valid
);
    logic [IDX_W-1:0] offset;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] low;

    // Rotating right puts requester last_ptr+1 at bit 0, so a plain
    // lowest-set-bit search yields round-robin order.
    assign offset = last_ptr + 1'b1;
    assign rot    = N_REQ'({req, req} >> offset);

    always_comb begin
        low = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) low = IDX_W'(i);
        end
    end

    assign sel_idx   = low + offset;
    assign sel_valid = |req;
endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with hold-until-release grants.
// Optional grant-hold timeout is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             release_in,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_flag
);
    arb_state_t       state, nxt_state;
    logic [IDX_W-1:0] last_ptr, nxt_last_ptr;
    logic [N_REQ-1:0] nxt_grant;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_valid;
    logic             nxt_flag;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             timeout_hit;
    logic             owner_done;

    rr_priority_select u_sel (
        .req       (req),
        .last_ptr  (last_ptr),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    assign owner_done = release_in || !req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] hold_cnt;

    // Counts GRANTED cycles; zero on the first cycle of every grant.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) hold_cnt <= '0;
        else                        hold_cnt <= hold_cnt + 8'd1;
    end

    assign timeout_hit = (state == GRANTED) && (hold_cnt == HOLD_LAST);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        nxt_state    = state;
        nxt_last_ptr = last_ptr;
        nxt_grant    = grant;
        nxt_idx      = grant_idx;
        nxt_valid    = grant_valid;
        nxt_flag     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && sel_valid) begin
                    nxt_state = GRANTED;
                    nxt_grant = N_REQ'(1) << sel_idx;
                    nxt_idx   = sel_idx;
                    nxt_valid = 1'b1;
                end
            end
            GRANTED: begin
                if (owner_done || timeout_hit) begin
                    nxt_state    = IDLE;
                    nxt_last_ptr = grant_idx;
                    nxt_grant    = '0;
                    nxt_idx      = '0;
                    nxt_valid    = 1'b0;
                    // A release or withdrawal on the timeout cycle wins; no flag.
                    nxt_flag     = !owner_done;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_ptr     <= RESET_PTR;
            grant        <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= nxt_state;
            last_ptr     <= nxt_last_ptr;
            grant        <= nxt_grant;
            grant_idx    <= nxt_idx;
            grant_valid  <= nxt_valid;
            timeout_flag <= nxt_flag;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed plan scenarios then random traffic vs. a behavioural model.
module tb_rr_arbiter_16;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TO = 255;
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, release_in;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid, timeout_flag;

    int n_chk = 0;
    int n_err = 0;

    // Model: who owns the resource, who owned it last, how long it has been held.
    bit m_valid;
    int m_idx, m_last, m_held;
    bit m_flag;

    rr_arbiter_16 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req          (req),
        .release_in   (release_in),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++)
            if (r[(last + k) % 16]) return (last + k) % 16;
        return -1;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_valid = 0; m_idx = 0; m_last = 15; m_held = 0; m_flag = 0;
        end else if (!m_valid) begin
            m_flag = 0;
            if (enable && req != 0) begin
                m_idx = rr_pick(req, m_last); m_valid = 1; m_held = 1;
            end
        end else begin
            bit done = release_in || !req[m_idx];
            bit expired = TO_ON && (m_held >= TO);
            m_flag = 0;
            if (done || expired) begin
                m_last = m_idx; m_valid = 0; m_idx = 0;
                m_flag = !done;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic cyc(input logic rs, input logic en, input logic [15:0] rq, input logic rel);
        reset = rs; enable = en; req = rq; release_in = rel;
        @(posedge clk);
        model_step();
        #1;
        chk("grant", grant, m_valid ? (32'd1 << m_idx) : 32'd0);
        chk("grant_idx", grant_idx, m_idx);
        chk("grant_valid", grant_valid, m_valid);
        chk("timeout_flag", timeout_flag, m_flag);
    endtask

    initial begin
        reset = 1; enable = 0; req = '0; release_in = 0;
        cyc(1, 0, 16'h0000, 0);
        cyc(1, 0, 16'h0000, 0);
        chk("rst_valid", grant_valid, 0);
        chk("rst_grant", grant, 0);

        // First grant after reset goes to requester 0 in one cycle.
        cyc(0, 1, 16'h0001, 0);
        chk("first_grant", grant, 32'h0001);
        chk("first_idx", grant_idx, 0);
        cyc(0, 1, 16'h0001, 1);
        chk("first_rel", grant_valid, 0);

        // Full rotation with everyone requesting.
        cyc(1, 0, 16'h0000, 0);
        for (int k = 0; k <= 16; k++) begin
            cyc(0, 1, 16'hFFFF, 0);
            chk("rr_idx", grant_idx, k % 16);
            cyc(0, 1, 16'hFFFF, 1);
            chk("rr_gap", grant_valid, 0);
        end

        // Wrap past 15 after last owner 14.
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 1, 16'h4000, 0);
        chk("w14", grant_idx, 14);
        cyc(0, 1, 16'h4000, 1);
        cyc(0, 1, 16'h4001, 0);
        chk("wrap0", grant_idx, 0);
        cyc(0, 1, 16'h4001, 1);
        cyc(0, 1, 16'h4001, 0);
        chk("wrap14", grant_idx, 14);

        // Withdrawal releases without release_in.
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 1, 16'h0020, 0);
        chk("wd5", grant_idx, 5);
        cyc(0, 1, 16'h0000, 0);
        chk("wd_drop", grant_valid, 0);
        cyc(0, 1, 16'h0070, 0);
        chk("wd6", grant_idx, 6);
        cyc(0, 1, 16'h0070, 1);
        cyc(0, 1, 16'h0030, 0);
        chk("wd4", grant_idx, 4);

        // enable gates new grants only.
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0100, 0);
        cyc(0, 0, 16'h0100, 0);
        chk("en_off", grant_valid, 0);
        cyc(0, 1, 16'h0100, 0);
        chk("en_on", grant_idx, 8);
        for (int k = 0; k < 3; k++) cyc(0, 0, 16'h0100, 0);
        chk("en_hold", grant_valid, 1);

        // Long hold: revoked after TO cycles when enabled, kept otherwise.
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 1, 16'h0008, 0);
        chk("to_g3", grant_idx, 3);
        if (TO_ON) begin
            for (int k = 0; k < TO - 1; k++) cyc(0, 1, 16'h0008, 0);
            chk("to_still", grant_valid, 1);
            cyc(0, 1, 16'h0008, 0);
            chk("to_drop", grant_valid, 0);
            chk("to_flag", timeout_flag, 1);
            cyc(0, 0, 16'h0008, 0);
            chk("to_pulse", timeout_flag, 0);
        end else begin
            for (int k = 0; k < 100; k++) cyc(0, 1, 16'h0008, 0);
            chk("hold100", grant_valid, 1);
            chk("hold_flag", timeout_flag, 0);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] rq;
            rq = 16'($urandom) & 16'($urandom) & 16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0 ? 16'h0000 : rq,
                $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
